ext_bus_host: RTL and testbench

EXT_BUS_HOST -- requirements
Module: ext_bus_host

---
 rtl/ext_bus_host.sv | 252 +++++++++++++++++++++++++
 tb/tb_ext_bus_host.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_bus_host.sv
// ext_bus_host: host end of a strobed 36-bit shared bus.
// Each transaction sends cmd, then addr, then len data words. Every word is
// one strobe cycle followed by STROBE_GAP wait cycles. The responder word is
// sampled in the last wait cycle. Transactions are separated by at least
// IDLE_GAP enable-low cycles.
module ext_bus_host #(
    parameter int STROBE_GAP = 3,
    parameter int IDLE_GAP   = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    inout  wire  [35:0] EXT_BUS,
    input  logic        start,
    input  logic [15:0] cmd,
    input  logic [15:0] addr,
    input  logic [7:0]  len,
    input  logic        abort,
    input  logic [15:0] wr_data,
    output logic        wr_ack,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic [7:0]  status,
    output logic        resp_ok,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int CNT_MAX = (STROBE_GAP > IDLE_GAP) ? STROBE_GAP : IDLE_GAP;
    // The counter only ever holds values 0..CNT_MAX-1.
    localparam int CW = $clog2(CNT_MAX);
    localparam logic [CW-1:0] SG_LOAD = CW'(STROBE_GAP - 1);
    localparam logic [CW-1:0] IG_LOAD = CW'(IDLE_GAP - 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, GAP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // The word index is 9 bits so that index len+1 = 256 does not wrap.
    logic [8:0]    idx_q, idx_d;
    logic [15:0]   cmd_q, cmd_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    len_q, len_d;
    logic [1:0]    enable_q, enable_d;
    logic          strobe_q, strobe_d;
    logic [15:0]   word_q, word_d;
    logic          wr_ack_q, wr_ack_d;
    logic [15:0]   rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic [7:0]    status_q, status_d;
    logic          resp_ok_q, resp_ok_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic          go_gap, gap_err, go_strobe;
    logic [8:0]    strobe_idx, last_idx;

    // Responder side of the bus: bit 32 is dout_en, [15:0] is the response word.
    logic [15:0] resp_word;
    logic        resp_dout_en, resp_claim;
    assign resp_word    = EXT_BUS[15:0];
    assign resp_dout_en = EXT_BUS[32];
    assign resp_claim   = resp_dout_en && (resp_word[15:8] == 8'hC0);

    // Host-driven fields come straight from flops; the responder fields float.
    assign EXT_BUS[35:34] = enable_q;
    assign EXT_BUS[33]    = strobe_q;
    assign EXT_BUS[31:16] = word_q;
    assign EXT_BUS[32]    = 1'bz;
    assign EXT_BUS[15:0]  = 16'bz;

    // Next-state and next-output logic of the transaction sequencer.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave a latch behind.
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        len_d      = len_q;
        enable_d   = enable_q;
        strobe_d   = 1'b0;
        word_d     = 16'h0000;
        wr_ack_d   = 1'b0;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        status_d   = status_q;
        resp_ok_d  = resp_ok_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        go_gap     = 1'b0;
        gap_err    = 1'b0;
        go_strobe  = 1'b0;
        strobe_idx = idx_q;
        last_idx   = {1'b0, len_q} + 9'd1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cmd_d    = cmd;
                    addr_d   = addr;
                    len_d    = len;
                    idx_d    = 9'd0;
                    busy_d   = 1'b1;
                    enable_d = 2'b01;
                    cnt_d    = SG_LOAD;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (abort) begin
                    go_gap  = 1'b1;
                    gap_err = 1'b1;
                end else if (cnt_q == '0) begin
                    go_strobe = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            STROBE: begin
                // An abort here still lets the strobe already on the bus
                // complete, but its response is never sampled.
                if (abort) begin
                    go_gap  = 1'b1;
                    gap_err = 1'b1;
                end else begin
                    cnt_d   = SG_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    go_gap  = 1'b1;
                    gap_err = 1'b1;
                end else if (cnt_q == '0) begin
                    if (idx_q == 9'd0) begin
                        status_d  = resp_word[7:0];
                        resp_ok_d = resp_claim;
                        if (!resp_claim) begin
                            go_gap  = 1'b1;
                            gap_err = 1'b1;
                        end else begin
                            go_strobe  = 1'b1;
                            strobe_idx = 9'd1;
                        end
                    end else begin
                        // The addr response (index 1) is discarded.
                        if (idx_q >= 9'd2) begin
                            rd_data_d  = resp_word;
                            rd_valid_d = 1'b1;
                        end
                        if (idx_q == last_idx) begin
                            go_gap = 1'b1;
                        end else begin
                            go_strobe  = 1'b1;
                            strobe_idx = idx_q + 9'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (go_strobe) begin
            state_d  = STROBE;
            idx_d    = strobe_idx;
            strobe_d = 1'b1;
            wr_ack_d = (strobe_idx >= 9'd2);
            if (strobe_idx == 9'd0) begin
                word_d = cmd_q;
            end else if (strobe_idx == 9'd1) begin
                word_d = addr_q;
            end else begin
                word_d = wr_data;
            end
        end

        if (go_gap) begin
            state_d  = GAP;
            cnt_d    = IG_LOAD;
            enable_d = 2'b00;
            done_d   = 1'b1;
            error_d  = gap_err;
        end
    end

    // Register all state and outputs; reset returns everything to idle/zero.
    always_ff @(posedge clk_sys) begin
        // NOTE: non-blocking assignments make every flop sample the
        // pre-edge values, independent of statement order.
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= 9'd0;
            cmd_q      <= 16'h0000;
            addr_q     <= 16'h0000;
            len_q      <= 8'h00;
            enable_q   <= 2'b00;
            strobe_q   <= 1'b0;
            word_q     <= 16'h0000;
            wr_ack_q   <= 1'b0;
            rd_data_q  <= 16'h0000;
            rd_valid_q <= 1'b0;
            status_q   <= 8'h00;
            resp_ok_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            enable_q   <= enable_d;
            strobe_q   <= strobe_d;
            word_q     <= word_d;
            wr_ack_q   <= wr_ack_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            status_q   <= status_d;
            resp_ok_q  <= resp_ok_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign wr_ack   = wr_ack_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign status   = status_q;
    assign resp_ok  = resp_ok_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_ext_bus_host.sv
// Self-checking bench for ext_bus_host. A bus responder and a wr_data
// producer are modelled here. Each transaction is scored against timing
// derived from the bus rules: the strobe for word i falls at
// STROBE_GAP + i*(STROBE_GAP+1) cycles after acceptance.
module tb_ext_bus_host;

    localparam int SG = 3;
    localparam int IG = 2;

    logic        clk_sys = 1'b0;
    logic        reset, start, abort;
    logic [15:0] cmd, addr, wr_data;
    logic [7:0]  len;
    logic        wr_ack, rd_valid, resp_ok, busy, done, error;
    logic [15:0] rd_data;
    logic [7:0]  status;

    wire  [35:0] ext_bus;
    logic        resp_en;
    logic [15:0] resp_word;
    assign ext_bus[32]   = resp_en;
    assign ext_bus[15:0] = resp_word;

    ext_bus_host #(.STROBE_GAP(SG), .IDLE_GAP(IG)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .EXT_BUS (ext_bus),
        .start   (start),
        .cmd     (cmd),
        .addr    (addr),
        .len     (len),
        .abort   (abort),
        .wr_data (wr_data),
        .wr_ack  (wr_ack),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .status  (status),
        .resp_ok (resp_ok),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_errors = 0;
    int low_run  = 0;
    int last_low = 0;
    bit after_txn = 1'b0;

    logic [15:0] td_resp [0:257];
    logic [15:0] td_wdata[0:256];
    logic [7:0]  exp_status;
    logic        exp_resp_ok;
    logic [15:0] exp_rd_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and observe just after the edge; track enable-low runs.
    task automatic tick();
        @(posedge clk_sys);
        #1;
        if (ext_bus[35:34] == 2'b00) begin
            low_run++;
        end else begin
            if (low_run != 0) last_low = low_run;
            low_run = 0;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 258; i++) td_resp[i] = 16'($urandom);
        for (int i = 0; i < 257; i++) td_wdata[i] = 16'($urandom);
    endtask

    function automatic int done_rel_nat(input int nat);
        return SG + (nat - 1) * (SG + 1) + SG + 1;
    endfunction

    task automatic check_all_zero();
        check("zero_bus_ctl", 32'(ext_bus[35:33]), 0);
        check("zero_bus_word", 32'(ext_bus[31:16]), 0);
        check("zero_flags", {26'd0, busy, done, error, wr_ack, rd_valid, resp_ok}, 0);
        check("zero_status", 32'(status), 0);
        check("zero_rd_data", 32'(rd_data), 0);
    endtask

    // One full transaction: accept, respond, score against the rule model.
    task automatic run_txn(input logic [15:0] c, input logic [15:0] a, input int n,
                           input logic den, input int ab_r, input logic keep);
        int rel, lat, strobes, acks, dn_cnt, dn_rel, en_off, fall_rel, bad, budget;
        int nat, d_nat, e_done, s, cs;
        logic dn_err, claimed, aborted, e_err;
        int st_rel[$], ack_rel[$], rv_rel[$];
        logic [15:0] st_word[$], rv_dat[$];
        int e_st_rel[$], e_ack_rel[$], e_rv_rel[$];
        logic [15:0] e_st_word[$], e_rv_dat[$];

        cmd = c; addr = a; len = n[7:0]; wr_data = td_wdata[0];
        resp_en = den; abort = 1'b0; start = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!busy && lat < 8);
        check("accept_lat", lat, 1);
        if (after_txn) check("gap_low_ge_idle", 32'(last_low >= IG), 1);
        // Scramble request inputs: the DUT must use its latched copies.
        cmd = 16'($urandom); addr = 16'($urandom); len = 8'($urandom);
        if (!keep) start = 1'b0;

        strobes = 0; acks = 0; dn_cnt = 0; dn_rel = -1; en_off = -1;
        fall_rel = -1; bad = 0; dn_err = 1'b0; rel = 0;
        budget = (n + 4) * (SG + 1) + IG + 20;
        while (rel < budget) begin
            if (ext_bus[33]) begin
                st_rel.push_back(rel);
                st_word.push_back(ext_bus[31:16]);
                if (strobes < 258) resp_word = td_resp[strobes];
                strobes++;
            end else if (ext_bus[31:16] != 16'h0000) begin
                bad++;
            end
            if (wr_ack) begin
                ack_rel.push_back(rel);
                acks++;
                wr_data = (acks < 257) ? td_wdata[acks] : 16'($urandom);
            end
            if (rd_valid) begin
                rv_rel.push_back(rel);
                rv_dat.push_back(rd_data);
            end
            if (done) begin
                dn_cnt++;
                dn_rel = rel;
                dn_err = error;
            end
            if (en_off < 0 && ext_bus[35:34] != 2'b01) en_off = rel;
            if (!busy) begin
                fall_rel = rel;
                break;
            end
            abort = (rel == ab_r);
            if (!keep) start = 1'($urandom_range(0, 1));
            tick();
            rel++;
        end
        abort = 1'b0;
        start = keep;

        // Reference: which strobes issue and which responses are sampled.
        claimed = den && (td_resp[0][15:8] == 8'hC0);
        nat     = claimed ? n + 2 : 1;
        d_nat   = done_rel_nat(nat);
        aborted = (ab_r >= 0) && (ab_r < d_nat);
        e_done  = aborted ? ab_r + 1 : d_nat;
        e_err   = aborted || !claimed;
        for (int i = 0; i < nat; i++) begin
            s  = SG + i * (SG + 1);
            cs = s + SG;
            if (!aborted || s <= ab_r) begin
                e_st_rel.push_back(s);
                e_st_word.push_back(i == 0 ? c : (i == 1 ? a : td_wdata[i - 2]));
                if (i >= 2) e_ack_rel.push_back(s);
            end
            if (!aborted || cs < ab_r) begin
                if (i == 0) begin
                    exp_status  = td_resp[0][7:0];
                    exp_resp_ok = claimed;
                end else if (i >= 2) begin
                    e_rv_rel.push_back(cs + 1);
                    e_rv_dat.push_back(td_resp[i]);
                    exp_rd_data = td_resp[i];
                end
            end
        end

        check("strobe_count", st_rel.size(), e_st_rel.size());
        for (int k = 0; k < st_rel.size() && k < e_st_rel.size(); k++) begin
            check("strobe_cycle", st_rel[k], e_st_rel[k]);
            check("strobe_word", 32'(st_word[k]), 32'(e_st_word[k]));
        end
        check("wr_ack_count", ack_rel.size(), e_ack_rel.size());
        for (int k = 0; k < ack_rel.size() && k < e_ack_rel.size(); k++)
            check("wr_ack_cycle", ack_rel[k], e_ack_rel[k]);
        check("rd_valid_count", rv_rel.size(), e_rv_rel.size());
        for (int k = 0; k < rv_rel.size() && k < e_rv_rel.size(); k++) begin
            check("rd_valid_cycle", rv_rel[k], e_rv_rel[k]);
            check("rd_valid_data", 32'(rv_dat[k]), 32'(e_rv_dat[k]));
        end
        check("status", 32'(status), 32'(exp_status));
        check("resp_ok", 32'(resp_ok), 32'(exp_resp_ok));
        check("rd_data_hold", 32'(rd_data), 32'(exp_rd_data));
        check("done_count", dn_cnt, 1);
        check("done_cycle", dn_rel, e_done);
        check("error", 32'(dn_err), 32'(e_err));
        check("enable_off_cycle", en_off, e_done);
        check("busy_fall_cycle", fall_rel, e_done + IG);
        check("word_zero_no_strobe", bad, 0);
        after_txn = 1'b1;
    endtask

    // Start a transaction, then reset it at relative cycle r.
    task automatic reset_mid(input int r);
        int lat, rel, dn;
        fill_random();
        cmd = 16'($urandom); addr = 16'($urandom); len = 8'd4;
        wr_data = td_wdata[0]; resp_en = 1'b1; resp_word = 16'hC0AA; start = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!busy && lat < 8);
        check("rst_mid_accept", 32'(busy), 1);
        start = 1'b0;
        rel = 0; dn = 0;
        while (rel < r) begin
            if (done) dn++;
            tick();
            rel++;
        end
        reset = 1'b1;
        tick();
        if (done) dn++;
        check_all_zero();
        check("rst_mid_no_done", dn, 0);
        reset = 1'b0;
        exp_status = 8'h00; exp_resp_ok = 1'b0; exp_rd_data = 16'h0000;
        after_txn = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, ab, nat;
        logic den, keep;
        reset = 1'b1; start = 1'b0; abort = 1'b0; cmd = 16'h0; addr = 16'h0;
        len = 8'h0; wr_data = 16'h0; resp_en = 1'b0; resp_word = 16'h0;
        exp_status = 8'h00; exp_resp_ok = 1'b0; exp_rd_data = 16'h0000;
        repeat (3) tick();
        check_all_zero();
        reset = 1'b0;
        tick();

        // Write: two data words, claimed with status 0x05.
        fill_random();
        td_wdata[0] = 16'h1111; td_wdata[1] = 16'h2222; td_resp[0] = 16'hC005;
        run_txn(16'h0061, 16'h0388, 2, 1'b1, -1, 1'b0);
        check("write_status", 32'(status), 32'h05);
        check("write_resp_ok", 32'(resp_ok), 1);

        // Read: three responses delivered in order.
        fill_random();
        td_resp[0] = 16'hC012;
        td_resp[2] = 16'hA001; td_resp[3] = 16'hA002; td_resp[4] = 16'hA003;
        run_txn(16'h0062, 16'h0100, 3, 1'b1, -1, 1'b0);
        check("read_rd_data_final", 32'(rd_data), 32'hA003);

        // Unclaimed: dout_en low.
        fill_random();
        run_txn(16'h0010, 16'h0200, 4, 1'b0, -1, 1'b0);
        check("unclaimed_resp_ok", 32'(resp_ok), 0);

        // Abort in WAIT after index 2 of len=5.
        fill_random();
        td_resp[0] = 16'hC001;
        run_txn(16'h0063, 16'h0300, 5, 1'b1, SG + 2 * (SG + 1) + 1, 1'b0);

        // Abort coincident with the addr strobe.
        fill_random();
        td_resp[0] = 16'hC002;
        run_txn(16'h0064, 16'h0400, 3, 1'b1, SG + (SG + 1), 1'b0);

        // Length boundaries: len=0 and len=255.
        fill_random();
        td_resp[0] = 16'hC033;
        run_txn(16'h0065, 16'h0500, 0, 1'b1, -1, 1'b0);
        fill_random();
        td_resp[0] = 16'hC044;
        run_txn(16'h0066, 16'h0600, 255, 1'b1, -1, 1'b0);

        // Reset in SETUP and in WAIT; a start right after release must be taken.
        reset_mid(1);
        fill_random();
        td_resp[0] = 16'hC055;
        run_txn(16'h0067, 16'h0700, 1, 1'b1, -1, 1'b0);
        reset_mid(SG + 1);
        fill_random();
        td_resp[0] = 16'hC066;
        run_txn(16'h0068, 16'h0800, 2, 1'b1, -1, 1'b0);

        // Back-to-back with start held high.
        for (int t = 0; t < 3; t++) begin
            fill_random();
            td_resp[0] = {8'hC0, 8'($urandom)};
            run_txn(16'($urandom), 16'($urandom), $urandom_range(0, 3), 1'b1, -1, t < 2);
        end

        // Randomized transactions.
        for (int t = 0; t < 30; t++) begin
            fill_random();
            n    = $urandom_range(0, 6);
            den  = ($urandom_range(0, 5) != 0);
            td_resp[0][15:8] = ($urandom_range(0, 4) != 0) ? 8'hC0 : 8'h3C;
            nat  = (den && td_resp[0][15:8] == 8'hC0) ? n + 2 : 1;
            ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, done_rel_nat(nat) + IG - 1) : -1;
            keep = ($urandom_range(0, 2) == 0);
            run_txn(16'($urandom), 16'($urandom), n, den, ab, keep);
        end

        start = 1'b0;
        repeat (IG + 4) tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
